g2b_share_arbiter: RTL

- Shares one Gray-to-binary conversion datapath among NREQ requesters.
- Each requester offers an N-bit Gray word over a valid/ready handshake.
- A round-robin arbiter grants one requester at a time. The block converts the word (MSB passes through; each lower bit is the XOR of its Gray bit and the next-higher binary bit) and returns the result tagged with the requester index.
- Sits between Gray-coded position/pointer sources and the binary consumers.

---
 rtl/g2b_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/g2b_share_arbiter.sv
// Round-robin shared Gray-to-binary converter: accept->out_valid in 2 cycles, one word per 3 cycles.
// Result held until out_ready with no new grants meanwhile; G2B_SHARE_ARBITER_CNT_EN adds saturating done_cnt.
module g2b_share_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready,
  output logic              busy
`ifdef G2B_SHARE_ARBITER_CNT_EN
  ,
  output logic [15:0]       done_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t         r_state;
  logic [N-1:0]   r_gray;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_rr_ptr;
  logic           r_out_valid;
  logic [N-1:0]   r_out_data;
  logic [IDW-1:0] r_out_id;
  logic           r_busy;

  logic           w_grant_vld;
  logic [IDW-1:0] w_grant;
  logic [IDW-1:0] w_next_ptr;
  logic [N-1:0]   w_bin;
  int             w_j;

  // First requesting index at or above rr_ptr, wrapping past NREQ-1.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_j         = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = int'(r_rr_ptr) + i;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_grant_vld && req_valid[w_j]) begin
        w_grant_vld = 1'b1;
        w_grant     = IDW'(w_j);
      end
    end
  end

  // Binary bit k is the XOR of all Gray bits from k up to the MSB.
  always_comb begin
    w_bin = '0;
    for (int k = 0; k < N; k++) begin
      w_bin[k] = ^(r_gray >> k);
    end
  end

  assign w_next_ptr = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

  // Gated by rst_n so no handshake can complete in a reset cycle.
  always_comb begin
    req_ready = '0;
    if (rst_n && r_state == IDLE && w_grant_vld) req_ready[w_grant] = 1'b1;
  end

  assign out_valid = r_out_valid & rst_n;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign busy      = r_busy;

`ifdef G2B_SHARE_ARBITER_CNT_EN
  logic [15:0] r_done_cnt;
  assign done_cnt = r_done_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gray      <= '0;
      r_id        <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_busy      <= 1'b0;
`ifdef G2B_SHARE_ARBITER_CNT_EN
      r_done_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_gray  <= req_data[w_grant*N +: N];
            r_id    <= w_grant;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_out_data  <= w_bin;
          r_out_id    <= r_id;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_rr_ptr    <= w_next_ptr;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
`ifdef G2B_SHARE_ARBITER_CNT_EN
            if (r_done_cnt != 16'hFFFF) r_done_cnt <= r_done_cnt + 16'd1;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
